bcd_scan_display: RTL



---
 rtl/bcd_disp_pkg.sv | 26 ++
 rtl/bcd_scan_display_decode.sv | 27 ++
 rtl/bcd_scan_display.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and glyph constants for the multiplexed BCD seven-segment display.
// All segment and anode encodings are active-low.
package bcd_disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/bcd_scan_display_decode.sv
// Combinational nibble to active-low {g,f,e,d,c,b,a} decoder.
// Any non-BCD nibble (above 9) renders as a dash.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit common-anode scan driver with a shadow/active double buffer that
// only swaps at frame boundaries, one blank cycle per digit slot against ghosting.
//
// Handshake: a transfer happens on any rising clk edge where in_valid && in_ready;
// in_ready is high exactly when the shadow register is empty, and upstream must
// hold bcd_hi/bcd_lo stable while in_valid is high and in_ready is low.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_hi,
  input  logic [7:0] bcd_lo,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       lz_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick,
  output state_e     dbg_state
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       dig;
  state_e           state_q;
  state_e           state_d;
  logic [15:0]      active;
  logic [15:0]      shadow;
  logic             pending;

  logic       cnt_last;
  logic       boundary;
  logic       accept;
  logic [3:0] cur_nib;
  logic [6:0] dec_seg;
  logic       lz_blank;
  logic       z3, z2, z1;

  assign cnt_last   = (cnt == CNT_LAST);
  assign boundary   = cnt_last && (dig == 2'd3);
  assign frame_tick = boundary;
  assign in_ready   = ~pending;
  assign accept     = in_valid && in_ready;
  assign dbg_state  = state_q;

  // Prescaler and digit-slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dig <= 2'd0;
    end else begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
      if (cnt_last) dig <= dig + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BLANK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   state_d = DRIVE;
      DRIVE:   if (cnt_last) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // The swap only happens when shadow is full, so accept and swap never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
    end else if (boundary && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= {bcd_hi, bcd_lo};
      pending <= 1'b1;
    end
  end

  always_comb begin
    cur_nib = active[3:0];
    case (dig)
      2'd0: cur_nib = active[3:0];
      2'd1: cur_nib = active[7:4];
      2'd2: cur_nib = active[11:8];
      2'd3: cur_nib = active[15:12];
      default: cur_nib = active[3:0];
    endcase
  end

  seg7_decode u_decode (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  // A digit is a leading zero when it and every digit to its left are zero.
  assign z3 = (active[15:12] == 4'd0);
  assign z2 = z3 && (active[11:8] == 4'd0);
  assign z1 = z2 && (active[7:4] == 4'd0);

  always_comb begin
    lz_blank = 1'b0;
    case (dig)
      2'd3: lz_blank = lz_en && z3;
      2'd2: lz_blank = lz_en && z2;
      2'd1: lz_blank = lz_en && z1;
      default: lz_blank = 1'b0;
    endcase
  end

  // Outputs load from the next state so they line up with the FSM cycle;
  // whenever the next state is DRIVE, dig is not about to change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else if (state_d == DRIVE) begin
      an  <= ~(4'b0001 << dig);
      seg <= lz_blank ? SEG_OFF : dec_seg;
    end else begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end
  end

endmodule
